ds_burst_router: RTL and testbench
==================================

# ds_burst_router

Packet-aware, parametrised downstream burst router. It latches each parsed frame header, maps the destination ID onto one of `DS_CHANNEL` output FIFOs and forwards exactly the header-declared number of data beats to that FIFO. Whole packets are dropped, never truncated, when the destination is unknown or its FIFO is programmably full. It sits between the downstream frame parser and the per-channel burst FIFOs, and keeps per-channel drop counters and an error pulse for the status registers.

## Interface
- `DS_CHANNEL`, 6, number of output channels (1..16)
- `DATA_W`, 128, beat width in bits; multiple of 8, power of two
- `DES_ID_BASE`, 8'h17, destination ID mapped to channel 0; channel k = `DES_ID_BASE`+k
- `LEN_W`, 16, width of the field-length (bytes) header field
- `CNT_W`, 16, width of each drop counter

- `sys_clk_i` in 1: single clock
- `rst_n_i` in 1: asynchronous, active-low reset
- `hdr_valid_i` in 1: one-cycle pulse; header fields below are valid
- `prased_des_id_i` in 8: destination ID
- `prased_data_field_len_i` in `LEN_W`: payload length in bytes
- `ds_burst_valid_i` in 1: data beat valid
- `ds_burst_data_i` in `DATA_W`: data beat
- `ds_burst_wr_en_o` out `DS_CHANNEL`: per-channel FIFO write enable
- `ds_burst_dout_o` out `DS_CHANNEL*DATA_W`: per-channel write data; channel k at [k*DATA_W +: DATA_W]
- `ds_burst_prog_full_i` in `DS_CHANNEL`: per-channel FIFO programmable full
- `ds_drop_cnt_o` out `DS_CHANNEL*CNT_W`: per-channel dropped-packet counters, saturating
- `ds_err_o` out 1: one-cycle pulse on a protocol error
- `ds_busy_o` out 1: high while in FWD or DROP

## Operation
- BYTES = DATA_W/8. Beats = ceil(len/BYTES) = (len + BYTES−1) >> log2(BYTES); the sum is computed at LEN_W+1 bits.
- idx = des_id − DES_ID_BASE. The ID is in range iff des_id ≥ base and idx < DS_CHANNEL.
- States: IDLE, FWD, DROP. Registers: `sel` (channel index), `rem` (beats remaining, LEN_W bits).
- IDLE, on `hdr_valid_i`:
  - len = 0: stay in IDLE; no counters change.
  - ID out of range: go to DROP with rem = beats; no counter change; pulse `ds_err_o`.
  - ID in range and `prog_full[idx]` = 1 at the header cycle: go to DROP; `drop_cnt[idx]`++.
  - Otherwise: go to FWD with sel = idx and rem = beats.
- FWD: each valid beat is written to channel `sel` and rem is decremented. When the last beat is written (rem = 1), go to IDLE. `prog_full` is ignored mid-packet; the FIFO headroom covers the maximum packet.
- DROP: each valid beat is discarded and rem is decremented. Go to IDLE after the last beat.
- A valid beat while in IDLE (and no same-cycle header) is discarded and pulses `ds_err_o`.
- `hdr_valid_i` while in FWD or DROP:
  - The current packet is aborted and `ds_err_o` pulses.
  - The new header is evaluated exactly as in IDLE, in the same cycle.
  - A beat valid in that same cycle belongs to the new packet.
- Header and beat in the same cycle while in IDLE: the beat is the first beat of the new packet and is routed by the new decision.
- Drop counters saturate at 2^CNT_W−1.
- Non-selected `ds_burst_dout_o` slices hold their last value.

## Timing
- Reset values: all `ds_burst_wr_en_o` = 0, `ds_burst_dout_o` = 0, `ds_drop_cnt_o` = 0, `ds_err_o` = 0, `ds_busy_o` = 0; state = IDLE, rem = 0, sel = 0.
- Latency: an input beat in cycle n appears as `wr_en`/`dout` in cycle n+1, fully registered. At most one `wr_en` bit is high per cycle.
- Throughput: one beat per cycle, with no bubbles between packets. A header may coincide with the last beat of the previous packet only if that beat completes it; otherwise it is an abort.
- Reset asserted mid-packet: outputs clear immediately and asynchronously. The remainder of the packet after reset is treated as stray beats (error pulses).
- `ds_err_o` and the counter increments are registered, one cycle after the causing input.

## Structure
- Package `ds_router_pkg`: state enum (IDLE/FWD/DROP), the BYTES/log2 helper function, and the default base ID constant.
- One sub-module, `ds_sat_counter` (parameter CNT_W; inputs inc and clr), instantiated once per channel in a generate loop.
- The FSM, beat calculation and output registers live in the top level.

## Test plan
1. Header ID 8'h19, len 64, 4 valid beats, all FIFOs free: `wr_en[2]` pulses 4 cycles at n+1, `dout[2]` equals the data, other channels stay 0, `busy` deasserts after the last beat.
2. Header ID 8'h18, len 17, `prog_full[1]` = 1: DROP for 2 beats, no `wr_en`, `drop_cnt[1]` = 1, `err` = 0.
3. Header ID 8'h30, len 32: 2 beats discarded, one `err` pulse, all counters unchanged.
4. Header ID 8'h17, len 64; after 2 beats a new header ID 8'h1c, len 16, arrives with a beat in the same cycle: `err` pulses, channel 0 receives 2 beats, channel 5 receives 1 beat.
5. Back-to-back packets to 8'h1a and 8'h1b (len 32 each) with continuous valid: 4 consecutive `wr_en` cycles, 2 on bit 3 then 2 on bit 4, no bubble.
6. Force `drop_cnt[0]` to 0xFFFE, then drop 3 packets: the counter holds at 0xFFFF. Assert reset mid-FWD: all outputs read 0 in the same cycle.

Source files
------------

// File: rtl/ds_router_pkg.sv
// Shared FSM state type, base-ID default and beat-size helpers for the
// downstream burst router.
package ds_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam logic [7:0] DES_ID_BASE_DEF = 8'h17;

  function automatic int beat_bytes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int beat_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/ds_sat_counter.sv
// Saturating up-counter used for the per-channel dropped-packet statistics.
module ds_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/ds_burst_router.sv
// Routes header-qualified bursts to one of DS_CHANNEL FIFOs, dropping whole
// packets for unknown destinations or full FIFOs, with drop counters.
module ds_burst_router
  import ds_router_pkg::*;
#(
  parameter int         DS_CHANNEL  = 6,
  parameter int         DATA_W      = 128,
  parameter logic [7:0] DES_ID_BASE = DES_ID_BASE_DEF,
  parameter int         LEN_W       = 16,
  parameter int         CNT_W       = 16
) (
  input  logic                         sys_clk_i,
  input  logic                         rst_n_i,
  input  logic                         hdr_valid_i,
  input  logic [7:0]                   prased_des_id_i,
  input  logic [LEN_W-1:0]             prased_data_field_len_i,
  input  logic                         ds_burst_valid_i,
  input  logic [DATA_W-1:0]            ds_burst_data_i,
  output logic [DS_CHANNEL-1:0]        ds_burst_wr_en_o,
  output logic [DS_CHANNEL*DATA_W-1:0] ds_burst_dout_o,
  input  logic [DS_CHANNEL-1:0]        ds_burst_prog_full_i,
  output logic [DS_CHANNEL*CNT_W-1:0]  ds_drop_cnt_o,
  output logic                         ds_err_o,
  output logic                         ds_busy_o
);

  localparam int BYTES = beat_bytes(DATA_W);
  localparam int SHIFT = beat_shift(DATA_W);
  localparam int SEL_W = (DS_CHANNEL > 1) ? $clog2(DS_CHANNEL) : 1;
  localparam int PAD_N = 1 << SEL_W;

  state_t           state_reg;
  logic [LEN_W-1:0] rem_reg;
  logic [SEL_W-1:0] sel_reg;
  logic             err_reg;

  logic [LEN_W:0]        len_sum;
  logic [LEN_W-1:0]      beats;
  logic [7:0]            idx;
  logic [SEL_W-1:0]      idx_sel;
  logic                  in_range;
  logic                  len_zero;
  logic [PAD_N-1:0]      pf_pad;
  state_t                hdr_state;
  logic                  hdr_err;
  logic                  cnt_hit;
  logic                  tail_beat;
  logic                  abort;
  logic                  wr_do;
  logic [SEL_W-1:0]      wr_ch;
  logic [DS_CHANNEL-1:0] cnt_inc;

  // Ceiling division by the beat size, widened so a max-length field cannot wrap.
  assign len_sum  = {1'b0, prased_data_field_len_i} + (LEN_W+1)'(BYTES - 1);
  assign beats    = LEN_W'(len_sum >> SHIFT);
  assign len_zero = (prased_data_field_len_i == '0);

  assign idx      = prased_des_id_i - DES_ID_BASE;
  assign idx_sel  = idx[SEL_W-1:0];
  assign in_range = (prased_des_id_i >= DES_ID_BASE) && (idx < 8'(DS_CHANNEL));

  always_comb begin
    pf_pad = '0;
    pf_pad[DS_CHANNEL-1:0] = ds_burst_prog_full_i;
  end

  always_comb begin
    hdr_state = ST_IDLE;
    hdr_err   = 1'b0;
    cnt_hit   = 1'b0;
    if (!len_zero) begin
      if (!in_range) begin
        hdr_state = ST_DROP;
        hdr_err   = 1'b1;
      end else if (pf_pad[idx_sel]) begin
        hdr_state = ST_DROP;
        cnt_hit   = 1'b1;
      end else begin
        hdr_state = ST_FWD;
      end
    end
  end

  // A header is legal mid-packet only when the same-cycle beat closes that packet.
  assign tail_beat = (state_reg != ST_IDLE) && ds_burst_valid_i && (rem_reg == LEN_W'(1));
  assign abort     = hdr_valid_i && (state_reg != ST_IDLE) && !tail_beat;

  always_comb begin
    wr_do = 1'b0;
    wr_ch = sel_reg;
    if (hdr_valid_i) begin
      if (tail_beat) begin
        wr_do = (state_reg == ST_FWD);
      end else if (ds_burst_valid_i && (hdr_state == ST_FWD)) begin
        wr_do = 1'b1;
        wr_ch = idx_sel;
      end
    end else if (ds_burst_valid_i && (state_reg == ST_FWD)) begin
      wr_do = 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= ST_IDLE;
      rem_reg   <= '0;
      sel_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      if (hdr_valid_i) begin
        err_reg <= abort || hdr_err;
        if (hdr_state == ST_FWD) begin
          sel_reg <= idx_sel;
        end
        if (hdr_state == ST_IDLE) begin
          state_reg <= ST_IDLE;
          rem_reg   <= '0;
        end else if (ds_burst_valid_i && !tail_beat) begin
          if (beats == LEN_W'(1)) begin
            state_reg <= ST_IDLE;
            rem_reg   <= '0;
          end else begin
            state_reg <= hdr_state;
            rem_reg   <= beats - LEN_W'(1);
          end
        end else begin
          state_reg <= hdr_state;
          rem_reg   <= beats;
        end
      end else if (ds_burst_valid_i) begin
        if (state_reg == ST_IDLE) begin
          err_reg <= 1'b1;
        end else begin
          rem_reg <= rem_reg - LEN_W'(1);
          if (rem_reg == LEN_W'(1)) begin
            state_reg <= ST_IDLE;
          end
        end
      end
    end
  end

  assign ds_err_o  = err_reg;
  assign ds_busy_o = (state_reg != ST_IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < DS_CHANNEL; gi++) begin : g_ch
      logic              wr_en_ch_reg;
      logic [DATA_W-1:0] dout_ch_reg;
      logic              hit;

      assign hit = wr_do && (wr_ch == SEL_W'(gi));

      // Unselected channels keep their last data word.
      always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          wr_en_ch_reg <= 1'b0;
          dout_ch_reg  <= '0;
        end else begin
          wr_en_ch_reg <= hit;
          if (hit) begin
            dout_ch_reg <= ds_burst_data_i;
          end
        end
      end

      assign ds_burst_wr_en_o[gi]                 = wr_en_ch_reg;
      assign ds_burst_dout_o[gi*DATA_W +: DATA_W] = dout_ch_reg;
      assign cnt_inc[gi] = hdr_valid_i && cnt_hit && (idx_sel == SEL_W'(gi));

      ds_sat_counter #(
        .CNT_W(CNT_W)
      ) u_drop_cnt (
        .clk  (sys_clk_i),
        .rst_n(rst_n_i),
        .inc  (cnt_inc[gi]),
        .clr  (1'b0),
        .cnt  (ds_drop_cnt_o[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_ds_burst_router.sv
// Directed and randomized bench for ds_burst_router against a packet-level
// reference model.
module tb_ds_burst_router;

  localparam int         DS    = 6;
  localparam int         DW    = 128;
  localparam int         LW    = 16;
  localparam int         CW    = 16;
  localparam logic [7:0] BASE  = 8'h17;
  localparam int         BYTES = DW / 8;
  localparam int         VW    = DS * DW;
  localparam int         CMAX  = (1 << CW) - 1;

  logic          clk         = 1'b0;
  logic          rst_n       = 1'b1;
  logic          hdr_valid   = 1'b0;
  logic [7:0]    des_id      = '0;
  logic [LW-1:0] field_len   = '0;
  logic          burst_valid = 1'b0;
  logic [DW-1:0] burst_data  = '0;
  logic [DS-1:0] prog_full   = '0;

  logic [DS-1:0]    wr_en;
  logic [VW-1:0]    dout;
  logic [DS*CW-1:0] drop_cnt;
  logic             err;
  logic             busy;

  always #5 clk = ~clk;

  ds_burst_router #(
    .DS_CHANNEL (DS),
    .DATA_W     (DW),
    .DES_ID_BASE(BASE),
    .LEN_W      (LW),
    .CNT_W      (CW)
  ) dut (
    .sys_clk_i              (clk),
    .rst_n_i                (rst_n),
    .hdr_valid_i            (hdr_valid),
    .prased_des_id_i        (des_id),
    .prased_data_field_len_i(field_len),
    .ds_burst_valid_i       (burst_valid),
    .ds_burst_data_i        (burst_data),
    .ds_burst_wr_en_o       (wr_en),
    .ds_burst_dout_o        (dout),
    .ds_burst_prog_full_i   (prog_full),
    .ds_drop_cnt_o          (drop_cnt),
    .ds_err_o               (err),
    .ds_busy_o              (busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Packet-level model: beats still owed by the open packet and where they go.
  int            m_left;
  int            m_dst;
  logic [VW-1:0] m_dout;
  int            m_cnt[DS];
  logic [DS-1:0] e_wr;
  logic          e_err;
  bit            chk_on = 1'b1;
  int            wr_seen[DS];
  int            err_seen;

  task automatic model_reset();
    m_left = 0;
    m_dst  = -1;
    m_dout = '0;
    e_wr   = '0;
    e_err  = 1'b0;
    for (int i = 0; i < DS; i++) m_cnt[i] = 0;
  endtask

  task automatic clear_stats();
    err_seen = 0;
    for (int i = 0; i < DS; i++) wr_seen[i] = 0;
  endtask

  task automatic model_put(input int ch, input logic [DW-1:0] d);
    if (ch >= 0) begin
      e_wr[ch] = 1'b1;
      m_dout[ch*DW +: DW] = d;
    end
  endtask

  task automatic model_step(input bit hdr, input logic [7:0] id, input int len,
                            input bit vld, input logic [DW-1:0] d);
    bit used;
    used  = 1'b0;
    e_wr  = '0;
    e_err = 1'b0;
    if (vld && m_left > 0 && (!hdr || m_left == 1)) begin
      model_put(m_dst, d);
      m_left--;
      used = 1'b1;
    end
    if (hdr) begin
      int ch;
      ch = int'(id) - int'(BASE);
      if (m_left > 0) e_err = 1'b1;
      m_left = 0;
      if (len != 0) begin
        if (ch < 0 || ch >= DS) begin
          e_err = 1'b1;
          m_dst = -1;
        end else if (prog_full[ch]) begin
          m_dst = -1;
          if (m_cnt[ch] < CMAX) m_cnt[ch]++;
        end else begin
          m_dst = ch;
        end
        m_left = (len + BYTES - 1) / BYTES;
        if (vld && !used) begin
          model_put(m_dst, d);
          m_left--;
        end
      end
    end else if (vld && !used) begin
      e_err = 1'b1;
    end
  endtask

  function automatic logic [DS*CW-1:0] exp_cnt();
    logic [DS*CW-1:0] v;
    v = '0;
    for (int i = 0; i < DS; i++) v[i*CW +: CW] = CW'(m_cnt[i]);
    return v;
  endfunction

  task automatic compare_all();
    for (int i = 0; i < DS; i++) if (wr_en[i]) wr_seen[i]++;
    if (err) err_seen++;
    if (chk_on) begin
      check_eq("wr_en", VW'(wr_en), VW'(e_wr));
      check_eq("dout", dout, m_dout);
      check_eq("err", VW'(err), VW'(e_err));
      check_eq("busy", VW'(busy), VW'(m_left > 0));
      check_eq("drop_cnt", VW'(drop_cnt), VW'(exp_cnt()));
    end
  endtask

  task automatic drive(input bit hdr, input logic [7:0] id, input int len,
                       input bit vld, input logic [DW-1:0] d);
    hdr_valid   = hdr;
    des_id      = id;
    field_len   = LW'(len);
    burst_valid = vld;
    burst_data  = d;
    model_step(hdr, id, len, vld, d);
    @(posedge clk);
    #1;
    hdr_valid   = 1'b0;
    burst_valid = 1'b0;
    compare_all();
  endtask

  function automatic logic [DW-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    model_reset();
    clear_stats();
    #1 rst_n = 1'b0;
    #1 compare_all();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // 1: plain forward to channel 2
    clear_stats();
    prog_full = '0;
    drive(1'b1, 8'h19, 64, 1'b0, '0);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 0, 1'b1, rnd_beat());
    check_eq("t1_ch2_beats", VW'(wr_seen[2]), VW'(4));
    check_eq("t1_busy_end", VW'(busy), VW'(0));
    $display("test1: channel 2 received %0d beats", wr_seen[2]);

    // 2: destination FIFO full, packet dropped and counted
    clear_stats();
    prog_full = 6'b000010;
    drive(1'b1, 8'h18, 17, 1'b0, '0);
    for (int i = 0; i < 2; i++) drive(1'b0, 8'h00, 0, 1'b1, rnd_beat());
    check_eq("t2_cnt1", VW'(drop_cnt[1*CW +: CW]), VW'(1));
    check_eq("t2_err", VW'(err_seen), VW'(0));
    $display("test2: drop_cnt[1]=%0d", drop_cnt[1*CW +: CW]);

    // 3: unknown destination
    clear_stats();
    prog_full = '0;
    drive(1'b1, 8'h30, 32, 1'b0, '0);
    for (int i = 0; i < 2; i++) drive(1'b0, 8'h00, 0, 1'b1, rnd_beat());
    check_eq("t3_err", VW'(err_seen), VW'(1));
    $display("test3: %0d error pulses", err_seen);

    // 4: abort with header and beat in the same cycle
    clear_stats();
    drive(1'b1, 8'h17, 64, 1'b0, '0);
    for (int i = 0; i < 2; i++) drive(1'b0, 8'h00, 0, 1'b1, rnd_beat());
    drive(1'b1, 8'h1c, 16, 1'b1, rnd_beat());
    drive(1'b0, 8'h00, 0, 1'b0, '0);
    check_eq("t4_err", VW'(err_seen), VW'(1));
    check_eq("t4_ch0", VW'(wr_seen[0]), VW'(2));
    check_eq("t4_ch5", VW'(wr_seen[5]), VW'(1));
    $display("test4: ch0=%0d ch5=%0d", wr_seen[0], wr_seen[5]);

    // 5: back-to-back packets without a bubble
    clear_stats();
    drive(1'b1, 8'h1a, 32, 1'b1, rnd_beat());
    drive(1'b0, 8'h00, 0, 1'b1, rnd_beat());
    drive(1'b1, 8'h1b, 32, 1'b1, rnd_beat());
    drive(1'b0, 8'h00, 0, 1'b1, rnd_beat());
    check_eq("t5_ch3", VW'(wr_seen[3]), VW'(2));
    check_eq("t5_ch4", VW'(wr_seen[4]), VW'(2));
    $display("test5: ch3=%0d ch4=%0d", wr_seen[3], wr_seen[4]);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      bit         hdr;
      bit         vld;
      int         len;
      logic [7:0] id;
      if ($urandom_range(0, 7) == 0) prog_full = DS'($urandom);
      hdr = (m_left == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 9))
        0:       id = 8'($urandom);
        1:       id = BASE + 8'(DS);
        2:       id = BASE - 8'd1;
        default: id = BASE + 8'($urandom_range(0, DS - 1));
      endcase
      len = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 80));
      vld = ($urandom_range(0, 4) != 0);
      if (hdr && len == 0) vld = 1'b0;
      drive(hdr, id, len, vld, rnd_beat());
    end
    $display("random: %0d comparisons so far", total);

    // 6: saturate drop counter 0
    prog_full = 6'b000001;
    chk_on = 1'b0;
    while (m_cnt[0] < CMAX - 1) drive(1'b1, BASE, 16, 1'b1, rnd_beat());
    chk_on = 1'b1;
    drive(1'b0, 8'h00, 0, 1'b0, '0);
    check_eq("t6_cnt_fffe", VW'(drop_cnt[CW-1:0]), VW'(16'hFFFE));
    for (int i = 0; i < 3; i++) drive(1'b1, BASE, 16, 1'b1, rnd_beat());
    check_eq("t6_cnt_sat", VW'(drop_cnt[CW-1:0]), VW'(16'hFFFF));
    $display("test6: drop_cnt[0]=%h", drop_cnt[CW-1:0]);

    // reset in the middle of a forwarded packet
    prog_full = '0;
    drive(1'b1, 8'h19, 64, 1'b1, rnd_beat());
    drive(1'b0, 8'h00, 0, 1'b1, rnd_beat());
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    clear_stats();
    for (int i = 0; i < 2; i++) drive(1'b0, 8'h00, 0, 1'b1, rnd_beat());
    check_eq("rst_stray_err", VW'(err_seen), VW'(2));
    $display("reset: %0d stray-beat error pulses", err_seen);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
